// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer (MSB-first) with a 2-entry output FIFO and sticky overrun flag.
// Optional even-parity check enabled by defining SHIFT_DESER_PARITY_EN.
module shift_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SHIFT_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  word_next;
  logic              push;
  logic [WIDTH-1:0]  push_data;

  logic [WIDTH-1:0]  mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fill;
  logic              pop;
  logic              full;

  assign word_next = {shreg[WIDTH-2:0], serial_in};
  assign busy      = (state != IDLE);

  // A completed word is offered to the FIFO on the edge that samples its final bit.
  always_comb begin
    push      = 1'b0;
    push_data = word_next;
`ifdef SHIFT_DESER_PARITY_EN
    push_data = shreg;
    if (state == PARITY && !pause && ((^shreg ^ serial_in) == 1'b0))
      push = 1'b1;
`else
    if (state == SHIFT && !pause && count == LAST)
      push = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
`ifdef SHIFT_DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
`ifdef SHIFT_DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (!pause) begin
        case (state)
          IDLE: begin
            if (start) begin
              shreg <= {{(WIDTH-1){1'b0}}, serial_in};
              count <= CW'(1);
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (count == LAST) begin
`ifdef SHIFT_DESER_PARITY_EN
              shreg <= word_next;
              count <= CW'(WIDTH);
              state <= PARITY;
`else
              shreg <= '0;
              count <= '0;
              state <= IDLE;
`endif
            end else begin
              shreg <= word_next;
              count <= count + 1'b1;
            end
          end
`ifdef SHIFT_DESER_PARITY_EN
          PARITY: begin
            parity_err <= ^shreg ^ serial_in;
            shreg      <= '0;
            count      <= '0;
            state      <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef SHIFT_DESER_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign out_valid = (fill != 2'd0);
  assign full      = (fill == 2'd2);
  assign pop       = out_valid && out_ready;
  assign data_out  = out_valid ? mem[rd_ptr] : '0;

  // When full, a simultaneous pop frees the slot the push writes into, so both proceed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      fill    <= 2'd0;
      overrun <= 1'b0;
    end else begin
      if (push && full && !pop)
        overrun <= 1'b1;
      if (push && (!full || pop)) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (push && (!full || pop) && !pop)
        fill <= fill + 2'd1;
      else if (pop && !push)
        fill <= fill - 2'd1;
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
// Directed self-checking bench for shift_deser at WIDTH=4.
// Parity scenarios run only when SHIFT_DESER_PARITY_EN is defined.
module tb_shift_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic       start;
  logic       pause;
  logic [3:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int compared   = 0;
  int mismatched = 0;

  shift_deser #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .start      (start),
    .pause      (pause),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge and are sampled by the following rising edge.
  task automatic applyStimulus(input logic s, input logic b, input logic p, input logic r);
    @(negedge clk);
    start     = s;
    serial_in = b;
    pause     = p;
    out_ready = r;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popWord();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic sendWord(input logic [3:0] w, input logic rdy_last);
    for (int i = 3; i >= 0; i--) begin
`ifdef SHIFT_DESER_PARITY_EN
      applyStimulus(i == 3, w[i], 1'b0, 1'b0);
`else
      applyStimulus(i == 3, w[i], 1'b0, (i == 0) ? rdy_last : 1'b0);
`endif
    end
`ifdef SHIFT_DESER_PARITY_EN
    applyStimulus(1'b0, ^w, 1'b0, rdy_last);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; serial_in = 1'b0; pause = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_perr", parity_err, 0);
    rst_n = 1'b1;

    // Single word, consumer stalled
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("w1_busy_mid", busy, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SHIFT_DESER_PARITY_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    checkOutput("w1_valid_early", out_valid, 0);
    idle();
    checkOutput("w1_valid", out_valid, 1);
    checkOutput("w1_data", data_out, 4'b1101);
    checkOutput("w1_busy", busy, 0);
    checkOutput("w1_perr", parity_err, 0);
    idle();
    checkOutput("w1_hold", data_out, 4'b1101);
    popWord();
    idle();
    checkOutput("w1_popped_valid", out_valid, 0);
    checkOutput("w1_popped_data", data_out, 0);

    // start ignored in IDLE while paused
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    checkOutput("pause_idle_busy", busy, 0);

    // Pause for 3 cycles after bit 2; a stray start mid-word is ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pause_busy", busy, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SHIFT_DESER_PARITY_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    checkOutput("pause_valid_early", out_valid, 0);
    idle();
    checkOutput("pause_valid", out_valid, 1);
    checkOutput("pause_data", data_out, 4'b1101);
    popWord();

    // Push and pop on the same edge with the buffer full
    sendWord(4'b1101, 1'b0);
    sendWord(4'b0011, 1'b0);
    sendWord(4'b1000, 1'b1);
    idle();
    checkOutput("full_pp_data", data_out, 4'b0011);
    checkOutput("full_pp_overrun", overrun, 0);
    popWord();
    idle();
    checkOutput("full_pp_data2", data_out, 4'b1000);
    popWord();
    idle();
    checkOutput("full_pp_empty", out_valid, 0);

    // Three words into a stalled consumer: third is dropped
    sendWord(4'b1101, 1'b0);
    sendWord(4'b0011, 1'b0);
    sendWord(4'b1000, 1'b0);
    idle();
    checkOutput("ovr_flag", overrun, 1);
    checkOutput("ovr_data0", data_out, 4'b1101);
    popWord();
    idle();
    checkOutput("ovr_data1", data_out, 4'b0011);
    popWord();
    idle();
    checkOutput("ovr_empty", out_valid, 0);
    checkOutput("ovr_sticky", overrun, 1);

    // Reset mid-word discards partial and buffered words
    sendWord(4'b1010, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; serial_in = 1'b1;
    #1;
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_valid", out_valid, 0);
    checkOutput("rstmid_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; serial_in = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid_nostart", busy, 0);
    sendWord(4'b0110, 1'b0);
    idle();
    checkOutput("rstmid_valid2", out_valid, 1);
    checkOutput("rstmid_data", data_out, 4'b0110);
    popWord();
    idle();

`ifdef SHIFT_DESER_PARITY_EN
    // Bad parity bit drops the word and pulses parity_err
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    checkOutput("par_err_pulse", parity_err, 1);
    checkOutput("par_err_valid", out_valid, 0);
    idle();
    checkOutput("par_err_clear", parity_err, 0);
    checkOutput("par_err_valid2", out_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
